sop_truth_scanner: RTL



---
 rtl/sop_pkg.sv | 26 ++
 rtl/sop_truth_scanner_settle_timer.sv | 37 +++
 rtl/sop_truth_scanner.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sop_pkg.sv
// Shared types and sizes for the SOP truth-table scanner.
package sop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int VEC_W      = 4;
  localparam int TT_W       = 16;
  localparam int CNT_W      = 5;
  localparam int TMR_W      = 4;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

  function automatic logic [CNT_W-1:0] popcount(input logic [TT_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < TT_W; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sop_truth_scanner_settle_timer.sv
// Settle counter: counts while enabled, clears on demand, ticks on its last settle cycle.
module settle_timer
  import sop_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(SETTLE - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/sop_truth_scanner.sv
// Walks vec through 0..15, samples f_in after SETTLE cycles per vector into a truth table.
// Optional compare against a latched expected mask when TTSCAN_COMPARE_EN is defined.
module sop_truth_scanner
  import sop_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic [VEC_W-1:0] vec_o,
  input  logic             f_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [TT_W-1:0]  table_o,
`ifdef TTSCAN_COMPARE_EN
  input  logic [TT_W-1:0]  expected_i,
`endif
  output logic             pass_o,
  output logic [CNT_W-1:0] mismatch_cnt_o
);

  if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
    $error("sop_truth_scanner: SETTLE out of range 1..15");
  end

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [TT_W-1:0]  table_q, table_d;
  logic             tmr_clr, tmr_en, tick;
  logic             exp_ld, res_ld, res_clr;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    table_d = table_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    exp_ld  = 1'b0;
    res_ld  = 1'b0;
    res_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          vec_d   = '0;
          table_d = '0;
          tmr_clr = 1'b1;
          exp_ld  = 1'b1;
          res_clr = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        tmr_en = 1'b1;
        if (tick) begin
          table_d[vec_q] = f_in_i;
          tmr_clr        = 1'b1;
          // The last vector leaves vec at 15; it returns to 0 only through DONE.
          if (&vec_q) begin
            res_ld  = 1'b1;
            state_d = DONE;
          end else begin
            vec_d = vec_q + VEC_W'(1);
          end
        end
      end
      DONE: begin
        vec_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      table_q <= table_d;
    end
  end

  assign vec_o   = vec_q;
  assign table_o = table_q;
  assign busy_o  = (state_q == SCAN);
  assign done_o  = (state_q == DONE);

`ifdef TTSCAN_COMPARE_EN
  logic [TT_W-1:0]  exp_q;
  logic             pass_q;
  logic [CNT_W-1:0] mm_q;

  // Results come from table_d so they are already valid in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q  <= '0;
      pass_q <= 1'b0;
      mm_q   <= '0;
    end else begin
      if (exp_ld) begin
        exp_q <= expected_i;
      end
      if (res_clr) begin
        pass_q <= 1'b0;
        mm_q   <= '0;
      end else if (res_ld) begin
        pass_q <= (table_d == exp_q);
        mm_q   <= popcount(table_d ^ exp_q);
      end
    end
  end

  assign pass_o         = pass_q;
  assign mismatch_cnt_o = mm_q;
`else
  logic unused_cmp;
  assign unused_cmp     = ^{exp_ld, res_ld, res_clr};
  assign pass_o         = 1'b0;
  assign mismatch_cnt_o = '0;
`endif

endmodule
